fpa_zp_rd: RTL and testbench

FPA_ZP_RD -- requirements
Module: fpa_zp_rd

---
 rtl/fpa_pkg.sv | 26 ++
 rtl/fpa_zp_rd.sv | 86 ++++++++
 tb/tb_fpa_zp_rd.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpa_pkg.sv
// Shared FPA definitions: ZP source select codes, unload FSM state type, last-word helper.
// Define FPA_ZP_FLAGS_EN to add the flags word to 3-word (dw=1) unloads.
package fpa_pkg;

    localparam logic [1:0] ZP_T0    = 2'b00;
    localparam logic [1:0] ZP_T16   = 2'b01;
    localparam logic [1:0] ZP_T32D  = 2'b10;
    localparam logic [1:0] ZP_FLAGS = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEL  = 2'd1,
        ST_OUT  = 2'd2,
        ST_DONE = 2'd3
    } fpa_zp_state_e;

    // Index of the final word of an unload; with flags the dw=1 unload gains the flags word.
    function automatic logic [1:0] zp_last_idx(input logic dw);
`ifdef FPA_ZP_FLAGS_EN
        return dw ? ZP_FLAGS : ZP_T16;
`else
        return dw ? ZP_T32D : ZP_T16;
`endif
    endfunction

endpackage

// File: rtl/fpa_zp_rd.sv
// Unloads the FPA result over the ZP bus one 16-bit word at a time with a valid/ready output.
// Optional macro FPA_ZP_FLAGS_EN appends a flags word (select 11) to dw=1 unloads.
module fpa_zp_rd
    import fpa_pkg::*;
(
    input  logic        clk_sys,
    input  logic        clr,
    input  logic        start,
    input  logic        dw,
    input  logic [0:15] zp,
    output logic        zpa,
    output logic        zpb,
    output logic        _0_zp,
    output logic [0:15] word,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        busy,
    output logic        done,
    output logic [0:1]  idx,
    output logic [1:0]  dbg_state
);

    // Handshake: a word moves on any rising edge where word_valid and word_ready are both 1;
    // word_valid never drops and word never changes until that edge.
    fpa_zp_state_e state;
    logic          dw_q;

    assign dbg_state = state;

    // All outputs are registered and set for the state being entered.
    always_ff @(posedge clk_sys) begin
        if (clr) begin
            state      <= ST_IDLE;
            idx        <= 2'd0;
            word       <= 16'd0;
            word_valid <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            zpa        <= 1'b0;
            zpb        <= 1'b0;
            _0_zp      <= 1'b1;
            dw_q       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        dw_q       <= dw;
                        idx        <= 2'd0;
                        busy       <= 1'b1;
                        _0_zp      <= 1'b0;
                        {zpb, zpa} <= ZP_T0;
                        state      <= ST_SEL;
                    end
                end
                ST_SEL: begin
                    word       <= zp;
                    word_valid <= 1'b1;
                    state      <= ST_OUT;
                end
                ST_OUT: begin
                    if (word_ready) begin
                        word_valid <= 1'b0;
                        if (idx == zp_last_idx(dw_q)) begin
                            done       <= 1'b1;
                            _0_zp      <= 1'b1;
                            {zpb, zpa} <= ZP_T0;
                            state      <= ST_DONE;
                        end else begin
                            idx        <= idx + 2'd1;
                            {zpb, zpa} <= idx + 2'd1;
                            state      <= ST_SEL;
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    idx   <= 2'd0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpa_zp_rd.sv
// Bench for fpa_zp_rd: directed scenarios plus randomized unloads against a word-level model.
// Honours FPA_ZP_FLAGS_EN the same way the design does.
module tb_fpa_zp_rd;

    logic        clk_sys = 1'b0;
    logic        clr = 1'b1;
    logic        start = 1'b0;
    logic        dw = 1'b0;
    logic [0:15] zp;
    logic        zpa, zpb, _0_zp;
    logic [0:15] word;
    logic        word_valid;
    logic        word_ready = 1'b0;
    logic        busy, done;
    logic [0:1]  idx;
    logic [1:0]  dbg_state;

    logic [15:0] regs [4];
    logic [15:0] exp_q [$];
    int n_cmp = 0;
    int n_fail = 0;

`ifdef FPA_ZP_FLAGS_EN
    localparam int WORDS_DW1 = 4;
`else
    localparam int WORDS_DW1 = 3;
`endif

    always #5 clk_sys = ~clk_sys;

    // FPA model: zeroed bus when _0_zp, otherwise the register chosen by the select lines.
    assign zp = _0_zp ? 16'h0000 : regs[{zpb, zpa}];

    fpa_zp_rd dut (
        .clk_sys(clk_sys), .clr(clr), .start(start), .dw(dw), .zp(zp),
        .zpa(zpa), .zpb(zpb), ._0_zp(_0_zp), .word(word), .word_valid(word_valid),
        .word_ready(word_ready), .busy(busy), .done(done), .idx(idx), .dbg_state(dbg_state)
    );

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1; start = 1'b1; word_ready = 1'b1;
        tick(); tick();
        n_cmp++;
        if ({word_valid, busy, done, _0_zp, zpb, zpa} !== 6'b000100 || idx !== 2'd0 || word !== 16'h0) begin
            n_fail++;
            $display("FAIL reset: vld/busy/done/0zp/zpb/zpa=%b%b%b%b%b%b idx=%0d word=%h, required 000100 idx=0 word=0000",
                     word_valid, busy, done, _0_zp, zpb, zpa, idx, word);
        end
        clr = 1'b0; start = 1'b0; word_ready = 1'b0;
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b required 0", busy);
        end
    endtask

    // dw=0, ready tied high: words at n+2 and n+4, done at n+5.
    task automatic test_basic();
        logic [15:0] exp_w [5];
        logic [1:0]  exp_s [5];
        logic        exp_v [5];
        logic        exp_d [5];
        regs[0] = 16'h1234; regs[1] = 16'hABCD; regs[2] = 16'h5555; regs[3] = 16'h7777;
        exp_v = '{0, 1, 0, 1, 0};
        exp_d = '{0, 0, 0, 0, 1};
        exp_s = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
        exp_w = '{16'h0, 16'h1234, 16'h1234, 16'hABCD, 16'hABCD};
        dw = 1'b0; word_ready = 1'b1; start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            start = 1'b0;
            n_cmp++;
            if (word_valid !== exp_v[k] || done !== exp_d[k] || busy !== 1'b1 ||
                (k < 4 && {zpb, zpa} !== exp_s[k]) || (k > 0 && word !== exp_w[k])) begin
                n_fail++;
                $display("FAIL basic edge n+%0d: vld=%b done=%b busy=%b sel=%b word=%h, required vld=%b done=%b busy=1 sel=%b word=%h",
                         k + 1, word_valid, done, busy, {zpb, zpa}, word, exp_v[k], exp_d[k], exp_s[k], exp_w[k]);
            end
        end
        tick();
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || _0_zp !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_end: busy=%b done=%b 0zp=%b, required 0 0 1", busy, done, _0_zp);
        end
        word_ready = 1'b0;
    endtask

    task automatic drain(input string name);
        int guard = 0;
        word_ready = 1'b1;
        while (done !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_drain: done=%b after %0d cycles, required 1", name, done, guard);
        end
        tick();
        word_ready = 1'b0;
    endtask

    // dw=1 with a 4-cycle stall on word 1.
    task automatic test_stall();
        for (int k = 0; k < 4; k++) regs[k] = 16'($urandom);
        dw = 1'b1; word_ready = 1'b1; start = 1'b1;
        tick(); start = 1'b0; dw = 1'b0;
        tick();
        tick(); word_ready = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if (word_valid !== 1'b1 || word !== regs[1] || {zpb, zpa} !== 2'b01 || idx !== 2'd1) begin
                n_fail++;
                $display("FAIL stall cycle %0d: vld=%b word=%h sel=%b idx=%0d, required 1 %h 01 1",
                         c, word_valid, word, {zpb, zpa}, idx, regs[1]);
            end
            if (c < 4) tick();
        end
        word_ready = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (word_valid !== 1'b1 || word !== regs[2] || {zpb, zpa} !== 2'b10) begin
            n_fail++;
            $display("FAIL stall_word2: vld=%b word=%h sel=%b, required 1 %h 10", word_valid, word, {zpb, zpa}, regs[2]);
        end
        drain("stall");
    endtask

    // clr during OUT of idx 1 aborts without done, then a fresh start begins at idx 0.
    task automatic test_clr_abort();
        int done_cnt = 0;
        for (int k = 0; k < 4; k++) regs[k] = 16'($urandom) | 16'h0001;
        dw = 1'b1; word_ready = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        tick();
        tick(); word_ready = 1'b0;
        tick();
        n_cmp++;
        if (word_valid !== 1'b1 || idx !== 2'd1) begin
            n_fail++;
            $display("FAIL abort_setup: vld=%b idx=%0d, required 1 1", word_valid, idx);
        end
        clr = 1'b1; word_ready = 1'b1; start = 1'b1;
        tick();
        n_cmp++;
        if ({word_valid, busy, done, _0_zp, zpb, zpa} !== 6'b000100 || idx !== 2'd0 || word !== 16'h0) begin
            n_fail++;
            $display("FAIL abort_clr: vld/busy/done/0zp/zpb/zpa=%b%b%b%b%b%b idx=%0d word=%h, required 000100 0 0000",
                     word_valid, busy, done, _0_zp, zpb, zpa, idx, word);
        end
        clr = 1'b0; start = 1'b0; word_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (done === 1'b1) done_cnt++;
        end
        n_cmp++;
        if (done_cnt != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_nodone: done pulses=%0d busy=%b, required 0 0", done_cnt, busy);
        end
        start = 1'b1; dw = 1'b0;
        tick(); start = 1'b0;
        tick();
        n_cmp++;
        if (word_valid !== 1'b1 || idx !== 2'd0 || {zpb, zpa} !== 2'b00 || word !== regs[0]) begin
            n_fail++;
            $display("FAIL abort_restart: vld=%b idx=%0d sel=%b word=%h, required 1 0 00 %h",
                     word_valid, idx, {zpb, zpa}, word, regs[0]);
        end
        drain("abort");
    endtask

    // start held high: a 2-word unload repeats every 6 edges (5 busy, 1 idle).
    task automatic test_start_held();
        dw = 1'b0; word_ready = 1'b1; start = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            tick();
            n_cmp++;
            if (busy !== ((k % 6) != 0) || done !== ((k % 6) == 5)) begin
                n_fail++;
                $display("FAIL start_held edge %0d: busy=%b done=%b, required %b %b",
                         k, busy, done, (k % 6) != 0, (k % 6) == 5);
            end
        end
        start = 1'b0;
        drain("held");
    endtask

    // Random dw, ready and mid-transfer start/dw noise, checked word-by-word against the register model.
    task automatic test_random(input int iters);
        for (int t = 0; t < iters; t++) begin
            logic        d;
            logic        prev_v, prev_x;
            logic [15:0] prev_w;
            int gap, n_xfer, guard, fin;
            d = 1'($urandom_range(0, 1));
            for (int k = 0; k < 4; k++) regs[k] = 16'($urandom);
            exp_q.delete();
            for (int k = 0; k < (d ? WORDS_DW1 : 2); k++) exp_q.push_back(regs[k]);
            dw = d; start = 1'b1; word_ready = 1'b0;
            gap = 0; n_xfer = 0; guard = 0; fin = 0; prev_v = 1'b0; prev_x = 1'b0; prev_w = '0;
            while (fin == 0 && guard < 200) begin
                tick();
                guard++; gap++;
                if (busy !== 1'b1) begin
                    n_cmp++;
                    if (_0_zp !== 1'b1 || {zpb, zpa} !== 2'b00) begin
                        n_fail++;
                        $display("FAIL rand_idle: 0zp=%b sel=%b, required 1 00", _0_zp, {zpb, zpa});
                    end
                end
                if (word_valid === 1'b1 && prev_v === 1'b0) begin
                    n_cmp++;
                    if (gap != 2) begin
                        n_fail++;
                        $display("FAIL rand_latency: word %0d after %0d cycles, required 2", n_xfer, gap);
                    end
                end
                if (word_valid === 1'b1 && prev_v === 1'b1 && !prev_x) begin
                    n_cmp++;
                    if (word !== prev_w) begin
                        n_fail++;
                        $display("FAIL rand_stable: word=%h, required %h", word, prev_w);
                    end
                end
                word_ready = ($urandom_range(0, 2) != 0);
                prev_x = 1'b0;
                if (word_valid === 1'b1 && word_ready) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL rand_extra: unexpected word %h", word);
                    end else begin
                        logic [15:0] e;
                        e = exp_q.pop_front();
                        if (word !== e || {zpb, zpa} !== 2'(n_xfer)) begin
                            n_fail++;
                            $display("FAIL rand_word %0d: word=%h sel=%b, required %h %b", n_xfer, word, {zpb, zpa}, e, 2'(n_xfer));
                        end
                    end
                    n_xfer++; gap = 0; prev_x = 1'b1;
                end
                if (done === 1'b1) begin
                    n_cmp++;
                    if (exp_q.size() != 0 || gap != 1) begin
                        n_fail++;
                        $display("FAIL rand_done: left=%0d gap=%0d, required 0 1", exp_q.size(), gap);
                    end
                    fin = 1;
                end
                prev_v = word_valid; prev_w = word;
                start = (fin == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
                dw = 1'($urandom_range(0, 1));
            end
            n_cmp++;
            if (fin == 0) begin
                n_fail++;
                $display("FAIL rand_timeout: iteration %0d never reached done", t);
            end
            word_ready = 1'b0;
            tick();
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) regs[k] = '0;
        test_reset();
        test_basic();
        test_stall();
        test_clr_abort();
        test_start_held();
        test_random(40);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
